// File: rtl/uart_pkg.sv
// Purpose: shared UART types, baud divisors and divisor select helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Wide enough for the slowest rate's divisor.
  localparam int unsigned DIV_W = 11;

  localparam logic [DIV_W-1:0] DIV_4800   = 11'd1302;
  localparam logic [DIV_W-1:0] DIV_9600   = 11'd651;
  localparam logic [DIV_W-1:0] DIV_115200 = 11'd54;
  localparam logic [DIV_W-1:0] DIV_TEST   = 11'd4;

  // Clocks per oversample tick for a given baud select.
  function automatic logic [DIV_W-1:0] sel_div(input logic [1:0] s);
    case (s)
      2'b00:   sel_div = DIV_4800;
      2'b01:   sel_div = DIV_9600;
      2'b10:   sel_div = DIV_115200;
      default: sel_div = DIV_TEST;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Purpose: counter-based clock-enable, one tick every div clocks.
// Latency: first tick div clocks after clear drops.
// Backpressure: none; clear holds the counter at zero.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk_in,
  input  logic             reset,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == (div - 11'd1));

  // Next count: wrap to zero on each tick, hold at zero while cleared.
  always_comb begin
    cnt_d = cnt_q + 11'd1;
    if (clear || tick) cnt_d = '0;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Purpose: UART serialiser, start + 8 data LSB-first + optional parity + stop bits.
// Latency: tx low the cycle after acceptance; tx_done (1+8+PARITY_EN+STOP_BITS) bit periods later.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is dropped, nothing queued.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [1:0] S,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  tx_state_t        state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic tick;
  logic bit_end;
  logic accept;
  logic last_stop;

  assign accept    = tx_valid && ready_q;
  assign bit_end   = tick && (os_cnt_q == OS_LAST);
  assign last_stop = (STOP_BITS < 2) || stop_cnt_q;

  // Baud counter is held at zero in IDLE, so it restarts exactly at acceptance.
  uart_baud_tick u_baud (
    .clk_in (clk_in),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .div    (div_q),
    .tick   (tick)
  );

  // Frame sequencing: every bit lasts OVERSAMPLE ticks; outputs computed one edge ahead.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    os_cnt_d   = os_cnt_q;
    div_d      = div_q;
    par_d      = par_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (state_q != IDLE && tick) begin
      os_cnt_d = bit_end ? '0 : os_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d    = START;
          shift_d    = tx_data;
          div_d      = sel_div(S);
          par_d      = (^tx_data) ^ (PARITY_ODD != 0);
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (last_stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a done pulse.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      os_cnt_q   <= '0;
      div_q      <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      os_cnt_q   <= os_cnt_d;
      div_q      <= div_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Purpose: self-checking bench for uart_transmitter (default, even- and odd-parity builds).
// Latency: each frame checked every cycle from acceptance to the done pulse.
// Backpressure: checks that bytes offered while busy are dropped.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst    [3];
  logic [1:0] s_sel  [3];
  logic [7:0] dat    [3];
  logic       vld    [3];
  logic       tx_w   [3];
  logic       rdy_w  [3];
  logic       busy_w [3];
  logic       done_w [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_transmitter u0 (
    .clk_in(clk), .reset(rst[0]), .S(s_sel[0]), .tx_data(dat[0]), .tx_valid(vld[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk_in(clk), .reset(rst[1]), .S(s_sel[1]), .tx_data(dat[1]), .tx_valid(vld[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1])
  );
  uart_transmitter #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk_in(clk), .reset(rst[2]), .S(s_sel[2]), .tx_data(dat[2]), .tx_valid(vld[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clocks per tick, straight from the baud table.
  function automatic int tb_div(input logic [1:0] sel);
    case (sel)
      2'b00:   return 1302;
      2'b01:   return 651;
      2'b10:   return 54;
      default: return 4;
    endcase
  endfunction

  // Offer a byte on instance idx and wait for the acceptance edge.
  task automatic accept(input int idx, input logic [7:0] b, input logic [1:0] sel);
    @(negedge clk);
    check($sformatf("i%0d ready before accept", idx), 32'(rdy_w[idx]), 32'd1);
    s_sel[idx] = sel;
    dat[idx]   = b;
    vld[idx]   = 1'b1;
    @(posedge clk);
  endtask

  // Called right after an acceptance edge. Sample j follows edge j after acceptance.
  // Expected line: 0, data LSB-first, parity (inst 1 even, inst 2 odd), one stop bit.
  task automatic check_frame(input int idx, input logic [7:0] b, input logic [1:0] sel,
                             input int limit, input logic nxt_vld, input logic [7:0] nxt_dat,
                             input bit disturb);
    logic bits [12];
    int   nb;
    int   per;
    int   len;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    nb = 9;
    if (idx != 0) begin
      bits[9] = (^b) ^ (idx == 2);
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb  = nb + 1;
    per = 16 * tb_div(sel);
    len = nb * per;
    for (int j = 0; j <= len && j < limit; j++) begin
      @(negedge clk);
      if (j == 0) begin
        vld[idx] = nxt_vld;
        dat[idx] = nxt_dat;
      end
      if (disturb && j == 200) begin
        s_sel[idx] = 2'b00;
        dat[idx]   = 8'hFF;
        vld[idx]   = 1'b1;
      end
      if (disturb && j == 201) vld[idx] = 1'b0;
      if (j < len) begin
        check($sformatf("i%0d b%02h tx j=%0d", idx, b, j), 32'(tx_w[idx]), 32'(bits[j / per]));
        check($sformatf("i%0d b%02h done j=%0d", idx, b, j), 32'(done_w[idx]), 32'd0);
        check($sformatf("i%0d b%02h ready j=%0d", idx, b, j), 32'(rdy_w[idx]), 32'd0);
        check($sformatf("i%0d b%02h busy j=%0d", idx, b, j), 32'(busy_w[idx]), 32'd1);
      end else begin
        check($sformatf("i%0d b%02h end tx", idx, b), 32'(tx_w[idx]), 32'd1);
        check($sformatf("i%0d b%02h end done", idx, b), 32'(done_w[idx]), 32'd1);
        check($sformatf("i%0d b%02h end ready", idx, b), 32'(rdy_w[idx]), 32'd1);
        check($sformatf("i%0d b%02h end busy", idx, b), 32'(busy_w[idx]), 32'd0);
      end
    end
  endtask

  // Line must stay idle: high, ready, no done.
  task automatic check_idle(input int idx, input int cycles, input string tag);
    for (int j = 0; j < cycles; j++) begin
      @(negedge clk);
      check($sformatf("%s tx j=%0d", tag, j), 32'(tx_w[idx]), 32'd1);
      check($sformatf("%s done j=%0d", tag, j), 32'(done_w[idx]), 32'd0);
      check($sformatf("%s ready j=%0d", tag, j), 32'(rdy_w[idx]), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] rb;
    int         ri;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; vld[i] = 1'b0; dat[i] = 8'h00; s_sel[i] = 2'b11;
    end

    // Reset values at the first edge.
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("i%0d reset tx", i), 32'(tx_w[i]), 32'd1);
      check($sformatf("i%0d reset ready", i), 32'(rdy_w[i]), 32'd1);
      check($sformatf("i%0d reset busy", i), 32'(busy_w[i]), 32'd0);
      check($sformatf("i%0d reset done", i), 32'(done_w[i]), 32'd0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Default build, fast rate, 0xA5: 640-clock frame.
    accept(0, 8'hA5, 2'b11);
    check_frame(0, 8'hA5, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);

    // Parity builds, 0x07: even -> 1, odd -> 0, 704-clock frames.
    accept(1, 8'h07, 2'b11);
    check_frame(1, 8'h07, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);
    accept(2, 8'h07, 2'b11);
    check_frame(2, 8'h07, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);

    // Back-to-back with tx_valid held: 0x55 then 0xAA, one idle-high clock between.
    accept(0, 8'h55, 2'b11);
    check_frame(0, 8'h55, 2'b11, 1 << 30, 1'b1, 8'hAA, 1'b0);
    @(posedge clk);
    check_frame(0, 8'hAA, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);

    // Mid-frame S change and a 0xFF offer: frame timing unchanged, 0xFF dropped.
    accept(0, 8'h96, 2'b11);
    check_frame(0, 8'h96, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b1);
    check_idle(0, 100, "after drop");
    s_sel[0] = 2'b11;

    // Reset during data bit 3 (samples 256..319), then a clean 0x3C frame.
    accept(0, 8'hC3, 2'b11);
    check_frame(0, 8'hC3, 2'b11, 280, 1'b0, 8'h00, 1'b0);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("abort tx", 32'(tx_w[0]), 32'd1);
    check("abort ready", 32'(rdy_w[0]), 32'd1);
    check("abort busy", 32'(busy_w[0]), 32'd0);
    check("abort done", 32'(done_w[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    check_idle(0, 400, "after abort");
    accept(0, 8'h3C, 2'b11);
    check_frame(0, 8'h3C, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);

    // 115200 rate: 864-clock bit periods.
    accept(0, 8'h5A, 2'b10);
    check_frame(0, 8'h5A, 2'b10, 1 << 30, 1'b0, 8'h00, 1'b0);

    // Random bytes on random builds with random idle gaps.
    for (int r = 0; r < 6; r++) begin
      ri = int'($urandom_range(0, 2));
      rb = 8'($urandom);
      repeat ($urandom_range(0, 20)) @(posedge clk);
      accept(ri, rb, 2'b11);
      check_frame(ri, rb, 2'b11, 1 << 30, 1'b0, 8'h00, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
